// File: rtl/scan_pattern_driver.sv
// Tester-side driver for a single scan chain: shifts a stimulus pattern in,
// pulses one capture cycle, unloads the response and compares it against an
// expected pattern under a care mask.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; pattern inputs latched on acceptance
// SHIFT   | CHAIN_LENGTH cycles, scan_enable=1, scan_in = load bit k
// CAPTURE | one functional cycle, scan_enable=0
// UNLOAD  | CHAIN_LENGTH cycles, scan_enable=1, scan_out sampled each edge
// CHECK   | one cycle, result registered, done pulsed on the next cycle
module scan_pattern_driver #(
  parameter int CHAIN_LENGTH = 32,
  parameter int CNT_W        = 6,
  parameter int FAIL_CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CHAIN_LENGTH-1:0] load_data,
  input  logic [CHAIN_LENGTH-1:0] expect_data,
  input  logic [CHAIN_LENGTH-1:0] expect_mask,
  input  logic                    scan_out,
  output logic                    scan_enable,
  output logic                    scan_in,
  output logic                    busy,
  output logic                    done,
  output logic                    mismatch,
  output logic [CHAIN_LENGTH-1:0] unload_data,
  output logic [FAIL_CNT_W-1:0]   fail_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_CHECK   = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [CNT_W-1:0]        cnt;
  logic                    cnt_tc;
  logic [CHAIN_LENGTH-1:0] load_sr;
  logic [CHAIN_LENGTH-1:0] expect_q;
  logic [CHAIN_LENGTH-1:0] mask_q;
  logic [CHAIN_LENGTH-1:0] resp_sr;
  logic                    scan_enable_nx;
  logic                    scan_in_nx;
  logic                    cmp_fail;

  assign cnt_tc   = (cnt == CNT_W'(CHAIN_LENGTH - 1));
  assign busy     = (state != S_IDLE);
  assign cmp_fail = |((resp_sr ^ expect_q) & mask_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; start outside IDLE is simply not looked at
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start)  state_nx = S_SHIFT;
      S_SHIFT:   if (cnt_tc) state_nx = S_CAPTURE;
      S_CAPTURE:             state_nx = S_UNLOAD;
      S_UNLOAD:  if (cnt_tc) state_nx = S_CHECK;
      S_CHECK:               state_nx = S_IDLE;
      default:               state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered scan pins, decoded from the upcoming state
  // so the flopped pins line up with the state they belong to. On acceptance
  // bit 0 comes straight from the input; later bits come from the shifter.
  always_comb begin
    scan_enable_nx = 1'b0;
    scan_in_nx     = 1'b0;
    case (state_nx)
      S_SHIFT: begin
        scan_enable_nx = 1'b1;
        scan_in_nx     = (state == S_IDLE) ? load_data[0] : load_sr[0];
      end
      S_UNLOAD: scan_enable_nx = 1'b1;
      default: ;
    endcase
  end

  // Scan pin registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_enable <= 1'b0;
      scan_in     <= 1'b0;
    end else begin
      scan_enable <= scan_enable_nx;
      scan_in     <= scan_in_nx;
    end
  end

  // Bit counter: runs through SHIFT and UNLOAD, cleared everywhere else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if ((state == S_SHIFT) || (state == S_UNLOAD)) begin
      cnt <= cnt_tc ? '0 : cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Pattern latches, stimulus shifter and response shifter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_sr  <= '0;
      expect_q <= '0;
      mask_q   <= '0;
      resp_sr  <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        load_sr  <= load_data >> 1;
        expect_q <= expect_data;
        mask_q   <= expect_mask;
      end else if (state == S_SHIFT) begin
        load_sr <= load_sr >> 1;
      end
      // first sample ends up in bit 0 after CHAIN_LENGTH shifts
      if (state == S_UNLOAD) resp_sr <= {scan_out, resp_sr[CHAIN_LENGTH-1:1]};
    end
  end

  // Result registers, done pulse and saturating failure counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done        <= 1'b0;
      mismatch    <= 1'b0;
      unload_data <= '0;
      fail_count  <= '0;
    end else begin
      done <= (state == S_CHECK);
      if (state == S_CHECK) begin
        mismatch    <= cmp_fail;
        unload_data <= resp_sr;
        if (cmp_fail && !(&fail_count)) fail_count <= fail_count + FAIL_CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/scan_pattern_driver.md
Name: scan_pattern_driver

Overview:
- Tester-side driver for one scan chain of a scan-inserted register bank.
- Serially loads a stimulus pattern into the chain through scan_in with scan_enable high, then pulses one capture cycle.
- Unloads the chain response from scan_out and compares it against an expected pattern under a care mask.
- Sits beside the scan-inserted bank on the same clock and produces the bank's scan_enable and scan_in inputs.

Parameters:
CHAIN_LENGTH, 32, number of scan flops in the driven chain (>=2)
CNT_W, 6, bit counter width; must satisfy 2^CNT_W > CHAIN_LENGTH
FAIL_CNT_W, 16, width of saturating failed-pattern counter

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request one pattern; sampled only in IDLE
load_data  input  CHAIN_LENGTH  stimulus pattern; bit 0 shifted first; latched when start accepted
expect_data  input  CHAIN_LENGTH  expected response; latched when start accepted
expect_mask  input  CHAIN_LENGTH  1 = compare bit; latched when start accepted
scan_out  input  1  serial response from chain tail
scan_enable  output  1  chain shift enable (registered)
scan_in  output  1  serial stimulus to chain head (registered)
busy  output  1  high in all states except IDLE
done  output  1  one-cycle pulse when result is valid
mismatch  output  1  result of last pattern; held until next done
unload_data  output  CHAIN_LENGTH  captured response; bit 0 = first bit sampled; held until next done
fail_count  output  FAIL_CNT_W  saturating count of patterns with mismatch

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, scan_enable=0, scan_in=0, busy=0, done=0, mismatch=0, unload_data=0, fail_count=0, counter=0. Takes effect immediately, including mid-operation. Partially shifted data is discarded.
- FSM states: IDLE, SHIFT, CAPTURE, UNLOAD, CHECK.
- IDLE:
  - On start=1, latch load_data, expect_data and expect_mask; clear counter; go to SHIFT.
  - start while busy is ignored, never queued.
- SHIFT (CHAIN_LENGTH cycles): scan_enable=1, scan_in=load_data[k] in the k-th SHIFT cycle (k=0..L-1). After the L-th cycle go to CAPTURE.
- CAPTURE (1 cycle): scan_enable=0, scan_in=0. Then clear counter and go to UNLOAD.
- UNLOAD (CHAIN_LENGTH cycles):
  - scan_enable=1, scan_in=0.
  - At each rising edge in UNLOAD, scan_out is sampled into response bit k (k=0..L-1).
  - After L samples go to CHECK.
- CHECK (1 cycle):
  - scan_enable=0.
  - mismatch <= |((response ^ expect_data) & expect_mask).
  - unload_data <= response.
  - fail_count increments if mismatch and saturates at all-ones.
  - done <= 1 for exactly one cycle; go to IDLE.
- Timing: done is high in the cycle following 2L+2 rising edges after the edge that accepted start. For L=8 that is 18 edges.
- Back-to-back operation: if start is high in the IDLE cycle coinciding with done, the next pattern is accepted there, so patterns repeat every 2L+3 cycles.
- Input stability: load_data, expect_data and expect_mask may change freely after acceptance.
- All-zero mask: mismatch is always 0.
- busy: busy=0 exactly in IDLE, including the cycle done is high.

Test Plan:
1. L=8, bench chain = 8-flop shift register, capture holds value; start, load_data=0xA5, expect_data=0xA5, mask=0xFF -> scan_in sequence 1,0,1,0,0,1,0,1; done 18 edges after start; unload_data=0xA5, mismatch=0, fail_count=0.
2. L=8, chain captures parallel D=0x3C in capture cycle; load_data=0xFF, expect_data=0x3C, mask=0xFF -> scan_enable low for exactly one cycle between shift and unload; unload_data=0x3C, mismatch=0.
3. Same as 2 with expect_data=0x3D, mask=0xFF -> mismatch=1, fail_count=1; repeat with mask=0xFE -> mismatch=0, fail_count stays 1.
4. start held high continuously for 3 patterns -> exactly 3 done pulses spaced 19 cycles apart; extra start pulses during busy produce no additional pattern.
5. Assert reset low in 4th SHIFT cycle -> scan_enable, scan_in, busy, done, fail_count all 0 without waiting for a clock edge. After release, a fresh start completes normally with correct result.
6. FAIL_CNT_W=2, five consecutive mismatching patterns -> fail_count sequence 1,2,3,3,3.
